// File: rtl/wb8_interconnect.sv
// Purpose: 8-bit Wishbone decoder from one CPU master to NSLAVES slaves. It has a stall lock, a watchdog and sticky error status.
// Latency: zero added cycles on routed accesses; unmapped and timed-out accesses end with a one-cycle error ack.
// Backpressure: a slave stalls by withholding ACK; the route is locked until ack, master abort or watchdog expiry.
module wb8_interconnect #(
    parameter int                         NSLAVES       = 2,
    parameter int                         SEL_W         = 4,
    parameter logic [NSLAVES*SEL_W-1:0]   SLAVE_MATCH   = {4'hF, 4'h0},
    parameter int                         DEFAULT_SLAVE = 0,
    parameter int                         TIMEOUT       = 16,
    parameter logic [7:0]                 ERR_DATA      = 8'hFF
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [31:0]              M_ADR_I,
    input  logic                     M_STB_I,
    input  logic                     M_CYC_I,
    output logic [7:0]               M_DAT_O,
    output logic                     M_ACK_O,
    output logic                     M_ERR_O,
    output logic [NSLAVES-1:0]       S_STB_O,
    input  logic [NSLAVES*8-1:0]     S_DAT_I,
    input  logic [NSLAVES-1:0]       S_ACK_I,
    input  logic                     ERR_CLR_I,
    output logic                     ERR_VALID_O,
    output logic [31:0]              ERR_ADR_O,
    output logic [7:0]               ERR_CNT_O
);

    // Slave index width; a single-slave build still needs a 1-bit index.
    localparam int              IW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    // A default slave outside the port range means "no match is an error".
    localparam bit              DEF_OK  = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < NSLAVES);
    localparam logic [IW-1:0]   DEF_IDX = DEF_OK ? IW'(DEFAULT_SLAVE) : '0;
    localparam logic [7:0]      TMO     = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   sel_q, sel_nxt;
    logic [IW-1:0]   dec_sel;
    logic [IW-1:0]   route_sel;
    logic            dec_hit;
    logic            unmapped;
    logic [31:0]     adr_q, adr_nxt;
    logic [7:0]      wdog, wdog_nxt;
    logic            stb;
    logic            sel_ack;
    logic            err_entry;

    assign stb = M_STB_I & M_CYC_I;

    // Region decode: the downward scan lets the lowest matching index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = DEF_IDX;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (M_ADR_I[31 -: SEL_W] == SLAVE_MATCH[i*SEL_W +: SEL_W]) begin
                dec_hit = 1'b1;
                dec_sel = IW'(i);
            end
        end
        unmapped = !dec_hit && !DEF_OK;
    end

    // A stalled access keeps its latched slave even if the master address moves.
    assign route_sel = (state == ST_WAIT) ? sel_q : dec_sel;
    assign sel_ack   = S_ACK_I[route_sel];

    // Next-state logic and bus routing for IDLE / WAIT / ERR.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        adr_nxt   = adr_q;
        wdog_nxt  = wdog;
        err_entry = 1'b0;
        S_STB_O   = '0;
        M_ACK_O   = 1'b0;
        M_ERR_O   = 1'b0;
        M_DAT_O   = S_DAT_I[{route_sel, 3'b000} +: 8];
        case (state)
            ST_IDLE: begin
                if (stb) begin
                    if (unmapped) begin
                        // Nothing to strobe; answer with an error ack next cycle.
                        state_nxt = ST_ERR;
                        adr_nxt   = M_ADR_I;
                        err_entry = 1'b1;
                    end else begin
                        S_STB_O[route_sel] = 1'b1;
                        M_ACK_O            = sel_ack;
                        if (!sel_ack) begin
                            state_nxt = ST_WAIT;
                            sel_nxt   = dec_sel;
                            adr_nxt   = M_ADR_I;
                            wdog_nxt  = 8'd1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!stb) begin
                    // Master abandoned the cycle: release quietly.
                    state_nxt = ST_IDLE;
                    wdog_nxt  = 8'd0;
                end else if (sel_ack) begin
                    S_STB_O[route_sel] = 1'b1;
                    M_ACK_O            = 1'b1;
                    state_nxt          = ST_IDLE;
                    wdog_nxt           = 8'd0;
                end else if (wdog >= TMO) begin
                    // Watchdog expiry: withdraw the strobe and terminate with an error.
                    state_nxt = ST_ERR;
                    err_entry = 1'b1;
                    wdog_nxt  = 8'd0;
                end else begin
                    S_STB_O[route_sel] = 1'b1;
                    wdog_nxt           = wdog + 8'd1;
                end
            end
            ST_ERR: begin
                M_ACK_O   = 1'b1;
                M_ERR_O   = 1'b1;
                M_DAT_O   = ERR_DATA;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched route/address and watchdog registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= ST_IDLE;
            sel_q <= '0;
            adr_q <= '0;
            wdog  <= 8'd0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
            adr_q <= adr_nxt;
            wdog  <= wdog_nxt;
        end
    end

    // Sticky error status; a new error beats a simultaneous clear.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ERR_VALID_O <= 1'b0;
            ERR_ADR_O   <= 32'd0;
            ERR_CNT_O   <= 8'd0;
        end else if (err_entry) begin
            ERR_VALID_O <= 1'b1;
            ERR_ADR_O   <= adr_nxt;
            if (ERR_CLR_I) begin
                ERR_CNT_O <= 8'd1;
            end else if (ERR_CNT_O != 8'hFF) begin
                ERR_CNT_O <= ERR_CNT_O + 8'd1;
            end
        end else if (ERR_CLR_I) begin
            ERR_VALID_O <= 1'b0;
            ERR_CNT_O   <= 8'd0;
        end
    end

endmodule

// File: tb/tb_wb8_interconnect.sv
// Purpose: randomized scoreboard bench for wb8_interconnect with 2 slaves, unmapped default and a 16-cycle watchdog.
// Latency: expected acks carry the absolute cycle they must appear in.
// Backpressure: slave ack latency is chosen per access, including never (watchdog path).
module tb_wb8_interconnect;

    localparam int         NS    = 2;
    localparam int         TMO   = 16;
    localparam logic [7:0] ERRD  = 8'hFF;
    localparam int         HANG  = 99;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       m_adr;
    logic              m_stb, m_cyc;
    logic [7:0]        m_dat;
    logic              m_ack, m_err;
    logic [NS-1:0]     s_stb;
    logic [NS*8-1:0]   s_dat;
    logic [NS-1:0]     s_ack;
    logic              err_clr;
    logic              err_valid;
    logic [31:0]       err_adr;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    wb8_interconnect #(
        .NSLAVES      (NS),
        .SEL_W        (4),
        .SLAVE_MATCH  (8'hF0),
        .DEFAULT_SLAVE(7),
        .TIMEOUT      (TMO),
        .ERR_DATA     (ERRD)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .M_ADR_I    (m_adr),
        .M_STB_I    (m_stb),
        .M_CYC_I    (m_cyc),
        .M_DAT_O    (m_dat),
        .M_ACK_O    (m_ack),
        .M_ERR_O    (m_err),
        .S_STB_O    (s_stb),
        .S_DAT_I    (s_dat),
        .S_ACK_I    (s_ack),
        .ERR_CLR_I  (err_clr),
        .ERR_VALID_O(err_valid),
        .ERR_ADR_O  (err_adr),
        .ERR_CNT_O  (err_cnt)
    );

    typedef struct {
        logic [7:0] dat;
        logic       err;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference error status, kept as plain numbers.
    int          mdl_valid = 0;
    int          mdl_cnt   = 0;
    logic [31:0] mdl_adr   = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Region rule: top nibble 0 -> slave 0, F -> slave 1, anything else unmapped.
    function automatic int ref_target(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        if (a[31:28] == 4'hF) return 1;
        return -1;
    endfunction

    task automatic chk_status();
        check("err_valid", 32'(err_valid), 32'(mdl_valid));
        check("err_cnt", 32'(err_cnt), 32'(mdl_cnt));
        check("err_adr", err_adr, mdl_adr);
    endtask

    // Monitor: every master ack must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        if (m_err === 1'b1 && m_ack !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL err_without_ack: m_err=1 m_ack=%b at cycle %0d", m_ack, cyc);
        end
        if (m_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: ack with dat %0h err %b at cycle %0d, none expected", m_dat, m_err, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_cycle", cyc, e.at);
                check("ack_data", 32'(m_dat), 32'(e.dat));
                check("ack_err", 32'(m_err), 32'(e.err));
            end
        end
    end

    // One master access. lat = slave ack delay in cycles (HANG = never);
    // abort_at drops the strobe at that cycle; clr_entry pulses the clear on the
    // cycle that enters the error state; rst_at pulses reset at that cycle.
    task automatic access(input logic [31:0] addr, input int lat, input int abort_at,
                          input bit clr_entry, input bit wander, input int rst_at);
        int         t;
        int         ack_c;
        bit         is_err;
        bit         aborted;
        bit         killed;
        logic [7:0] d;
        logic [NS-1:0] exp_stb;
        t       = ref_target(addr);
        is_err  = (t < 0) || (lat >= TMO);
        ack_c   = (t < 0) ? 1 : (is_err ? TMO + 1 : lat);
        aborted = (t >= 0) && (abort_at > 0) && (abort_at < ack_c);
        killed  = (rst_at >= 0) && (rst_at < ack_c);
        d       = 8'($urandom);
        for (int c = 0; c <= ack_c; c++) begin
            @(posedge clk);
            #1;
            if (c == 0 && !aborted && !killed) begin
                exp_t e;
                e.dat = is_err ? ERRD : d;
                e.err = is_err;
                e.at  = cyc + ack_c;
                exp_q.push_back(e);
            end
            rst     = (killed && c == rst_at);
            m_cyc   = 1'b1;
            m_stb   = !(aborted && c == abort_at);
            m_adr   = (c > 0 && wander) ? $urandom : addr;
            s_dat   = 16'($urandom);
            s_ack   = 2'($urandom);
            err_clr = clr_entry && is_err && (c == ack_c - 1);
            if (t >= 0) begin
                s_ack[t] = (c == lat) && !is_err;
                if (c == lat) s_dat[t*8 +: 8] = d;
            end
            exp_stb = '0;
            if (t >= 0 && m_stb && c < (is_err ? TMO : lat + 1)) exp_stb[t] = 1'b1;
            @(negedge clk);
            check("s_stb", 32'(s_stb), 32'(exp_stb));
            if (c == 0) chk_status();
            if (killed && c == rst_at) begin
                mdl_valid = 0;
                mdl_cnt   = 0;
                mdl_adr   = 32'd0;
                break;
            end
            if (aborted && c == abort_at) break;
            if (is_err && c == ack_c - 1) begin
                mdl_valid = 1;
                mdl_adr   = addr;
                mdl_cnt   = clr_entry ? 1 : ((mdl_cnt >= 255) ? 255 : mdl_cnt + 1);
            end
        end
    endtask

    // Idle cycles between accesses, with stray acks and an occasional status clear.
    task automatic gap();
        bit clr;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_stb   = 1'b0;
        m_cyc   = 1'b0;
        m_adr   = $urandom;
        s_ack   = 2'($urandom);
        s_dat   = 16'($urandom);
        clr     = ($urandom_range(0, 3) == 0);
        err_clr = clr;
        @(negedge clk);
        check("idle_s_stb", 32'(s_stb), 32'd0);
        check("scoreboard_drained", exp_q.size(), 0);
        chk_status();
        if (clr) begin
            mdl_valid = 0;
            mdl_cnt   = 0;
        end
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        s_ack   = '0;
        @(negedge clk);
        chk_status();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          lat, ab;
        rst     = 1'b1;
        m_adr   = 32'd0;
        m_stb   = 1'b0;
        m_cyc   = 1'b0;
        s_dat   = '0;
        s_ack   = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        chk_status();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed scenarios.
        access(32'h0000_0010, 0, 0, 1'b0, 1'b0, -1);       gap();
        access(32'hF000_0000, 3, 0, 1'b0, 1'b1, -1);       gap();
        access(32'hF000_0000, HANG, 0, 1'b0, 1'b0, -1);    gap();
        access(32'h3000_0000, 0, 0, 1'b0, 1'b0, -1);       gap();
        access(32'hF000_0000, HANG, 5, 1'b0, 1'b0, -1);
        access(32'h0000_0010, 1, 0, 1'b0, 1'b0, -1);       gap();
        access(32'hF000_0000, 2, 0, 1'b0, 1'b0, -1);
        access(32'h0000_0004, HANG, 0, 1'b1, 1'b1, -1);    gap();

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a[31:28] = 4'h0;
                1: a[31:28] = 4'hF;
                2: a[31:28] = 4'($urandom_range(1, 14));
                default: ;
            endcase
            lat = $urandom_range(0, 6);
            if (lat == 6) lat = HANG;
            ab = 0;
            if (lat >= 2 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(1, (lat == HANG) ? 15 : lat - 1);
            access(a, lat, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 1) == 1) gap();
        end

        // Reset in the middle of a stalled access, then an unmapped access right after.
        access(32'hF000_0000, HANG, 0, 1'b0, 1'b0, 4);
        access(32'h3000_0000, 0, 0, 1'b0, 1'b0, -1);
        gap();
        access(32'h0000_0020, 2, 0, 1'b0, 1'b0, -1);
        gap();

        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb8_interconnect.md
Name: wb8_interconnect

Overview:
- Parametrised 8-bit Wishbone address decoder/arbiter between the single CPU master and NSLAVES slaves.
- Successor to the fixed two-way (RAM/LEDs) testbench decoder. Adds:
  - configurable slave address regions,
  - transaction lock once a cycle stalls,
  - bus watchdog that terminates hung accesses,
  - sticky error status.
- Slaves take address, write data and write-enable directly from the master bus. This block routes only strobe, read data and acknowledge.

Parameters:
- NSLAVES, 2: number of slave ports (1..16).
- SEL_W, 4: number of top address bits used for decode (ADR[31:32-SEL_W]).
- SLAVE_MATCH, {4'hF,4'h0}: packed NSLAVES*SEL_W. Field i is the region value for slave i.
- DEFAULT_SLAVE, 0: slave used when no region matches. A value >= NSLAVES means "unmapped → error".
- TIMEOUT, 16: wait cycles before the watchdog terminates an access (1..255).
- ERR_DATA, 8'hFF: value on M_DAT_O during an error termination.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  synchronous active-high reset
- M_ADR_I  in  32  master address
- M_STB_I  in  1  master strobe
- M_CYC_I  in  1  master cycle
- M_DAT_O  out  8  read data to master
- M_ACK_O  out  1  acknowledge to master
- M_ERR_O  out  1  error termination (asserted together with M_ACK_O)
- S_STB_O  out  NSLAVES  per-slave strobe
- S_DAT_I  in  NSLAVES*8  packed slave read data, slave i at [8i+7:8i]
- S_ACK_I  in  NSLAVES  per-slave acknowledge
- ERR_CLR_I  in  1  clears sticky error status
- ERR_VALID_O  out  1  sticky: at least one error since clear
- ERR_ADR_O  out  32  address of most recent errored access
- ERR_CNT_O  out  8  saturating error count

Behaviour:
- Decode:
  - Slave i matches when M_ADR_I[31:32-SEL_W] == SLAVE_MATCH field i.
  - On multiple matches, the lowest index wins.
  - No match selects DEFAULT_SLAVE; if DEFAULT_SLAVE >= NSLAVES the access is unmapped.
- States: IDLE, WAIT, ERR. Strobe qualifier stb = M_STB_I & M_CYC_I.
- IDLE:
  - Routing is combinational from the live decode (zero added latency).
  - S_STB_O[sel] = stb; all other S_STB_O bits are 0.
  - M_ACK_O = S_ACK_I[sel] & stb; M_DAT_O = S_DAT_I[sel].
  - stb & unmapped → go to ERR; latch M_ADR_I; no slave is strobed.
  - stb & no ack → go to WAIT; latch sel and M_ADR_I; wdog = 1.
  - stb & ack → stay in IDLE (single-cycle access).
- WAIT:
  - Routing uses the latched sel. Address changes are ignored for routing.
  - stb & ack → go to IDLE.
  - !stb (master abort) → go to IDLE, no error.
  - Otherwise wdog increments. When wdog == TIMEOUT, S_STB_O is forced to 0 in that cycle and the state goes to ERR.
- ERR (exactly one cycle):
  - M_ACK_O = 1, M_ERR_O = 1, M_DAT_O = ERR_DATA, S_STB_O = 0.
  - Next state is IDLE.
  - The CPU sees a normal ack carrying ERR_DATA, so it never hangs.
- M_ACK_O never reflects an unselected slave's ack. Stray acks are ignored.
- Error status:
  - On entry to ERR: ERR_VALID_O <= 1; ERR_ADR_O <= latched address; ERR_CNT_O increments, saturating at 255.
  - ERR_CLR_I clears ERR_VALID_O and ERR_CNT_O; ERR_ADR_O is kept.
  - ERR_CLR_I in the same cycle as an error entry: the set wins, ERR_VALID_O = 1 and ERR_CNT_O = 1.
- Reset values: state IDLE, wdog 0, ERR_VALID_O 0, ERR_ADR_O 0, ERR_CNT_O 0, M_ERR_O 0, S_STB_O 0.
  - Reset mid-WAIT drops S_STB_O in the cycle after the reset edge. No error is recorded.
- Width rules:
  - wdog is 8 bits.
  - The packed buses are indexed by the parameter-derived slice.
  - NSLAVES = 1 is legal; that slave is always selected unless unmapped.

Test Plan:
- NSLAVES=2 defaults, read ADR 0x00000010, slave0 acks same cycle with 0x5A → S_STB_O=01, M_ACK_O=1, M_DAT_O=0x5A, no state change, S_STB_O[1]=0.
- Write ADR 0xF0000000, slave1 acks after 3 cycles; master changes ADR to 0x0 mid-wait → S_STB_O stays 10 throughout, ack after 3 cycles, ERR_CNT_O=0.
- Slave1 never acks, TIMEOUT=16 → at wait cycle 16 S_STB_O=0; next cycle M_ACK_O=M_ERR_O=1, M_DAT_O=0xFF; ERR_VALID_O=1, ERR_ADR_O=0xF0000000, ERR_CNT_O=1.
- DEFAULT_SLAVE=7, access ADR 0x30000000 → no S_STB_O, one-cycle error ack in the next cycle, ERR_ADR_O=0x30000000.
- Master drops STB after 5 wait cycles → return to IDLE, no error; a following access to slave0 completes normally.
- ERR_CLR_I asserted in the same cycle as a timeout error entry → ERR_VALID_O=1, ERR_CNT_O=1. Then RST_I asserted during WAIT → all status 0, S_STB_O=0 after the edge.
